conv_frame_encoder: RTL and testbench

- Parametrised UART-side convolutional encoding engine.
- Collects a frame of `PAYLOAD_BYTES` received bytes and encodes it bit-serially with a rate-1/2 encoder of constraint length `K`, with configurable generators and optional tail termination.
- Buffers the encoded stream and drives the byte transmitter automatically or one byte per request.
- Sits between `async_receiver` and `async_transmitter`. It replaces the fixed 4-byte, K=3, button-driven flow.

---
 rtl/conv_frame_encoder.sv | 178 +++++++++++++++++
 tb/tb_conv_frame_encoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_encoder.sv
// conv_frame_encoder: collects a payload frame, convolutionally encodes it
// (rate 1/2, constraint length K) and hands the coded bytes to a UART tx.
module conv_frame_encoder #(
  parameter int PAYLOAD_BYTES = 4,
  parameter int K             = 3,
  parameter int G0            = 7,
  parameter int G1            = 5,
  parameter int TAIL          = 1,
  parameter int AUTO_SEND     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       abort,
  input  logic       send_req,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int PBITS     = 8 * PAYLOAD_BYTES;
  localparam int TBITS     = (TAIL != 0) ? K - 1 : 0;
  localparam int IB        = PBITS + TBITS;
  localparam int OB        = 2 * IB;
  localparam int OUT_BYTES = (OB + 7) / 8;
  localparam int RW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int BW = $clog2(IB);
  localparam int IW = $clog2(OUT_BYTES);
  localparam int PW = $clog2(PBITS);
  localparam int OW = $clog2(8 * OUT_BYTES);

  localparam logic [RW-1:0] RX_LAST  = RW'(PAYLOAD_BYTES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(IB - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(OUT_BYTES - 1);
  localparam logic [K-1:0]  GM0      = K'(G0);
  localparam logic [K-1:0]  GM1      = K'(G1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_ENCODE,
    S_SEND,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e                 state_q;
  logic [RW-1:0]          rx_cnt_q;
  logic [BW-1:0]          bit_q;
  logic [IW-1:0]          idx_q;
  logic [K-2:0]           s_q;
  logic                   pend_q;
  logic [PBITS-1:0]       pbuf_q;
  logic [8*OUT_BYTES-1:0] obuf_q;
  logic [7:0]             txd_q;
  logic                   fd_q;
  logic                   ovr_q;

  logic [IB-1:0] ibits;
  logic [K-1:0]  win;
  logic          c0;
  logic          c1;
  logic          go;
  logic [7:0]    obyte;
  logic [PW-1:0] ppos;
  logic [OW-1:0] opos;
  logic [OW-1:0] bpos;

  // Tail bits fall out as zeros from the zero-extension past the payload.
  assign ibits = IB'(pbuf_q);
  assign win   = {s_q, ibits[bit_q]};
  assign c0    = ^(win & GM0);
  assign c1    = ^(win & GM1);
  assign ppos  = PW'({rx_cnt_q, 3'b000});
  assign opos  = OW'({bit_q, 1'b0});
  assign bpos  = OW'({idx_q, 3'b000});
  assign obyte = obuf_q[bpos +: 8];

  // Start is decided in the SEND cycle itself so it can rise on entry.
  assign go = (state_q == S_SEND) && !tx_busy && !abort &&
              ((AUTO_SEND != 0) || pend_q);

  assign tx_start   = go;
  assign tx_data    = go ? obyte : txd_q;
  assign busy       = (state_q != S_COLLECT);
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

  // Frame FSM: collect, encode one bit per cycle, then pace bytes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_COLLECT;
      rx_cnt_q <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      s_q      <= '0;
      pend_q   <= 1'b0;
      pbuf_q   <= '0;
      obuf_q   <= '0;
      txd_q    <= '0;
      fd_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if ((AUTO_SEND == 0) && send_req) begin
        pend_q <= 1'b1;
      end
      if (abort) begin
        state_q  <= S_COLLECT;
        rx_cnt_q <= '0;
        bit_q    <= '0;
        idx_q    <= '0;
        s_q      <= '0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        if (rx_valid && (state_q != S_COLLECT)) begin
          ovr_q <= 1'b1;
        end
        unique case (state_q)
          S_COLLECT: begin
            if (rx_valid) begin
              pbuf_q[ppos +: 8] <= rx_data;
              if (rx_cnt_q == RX_LAST) begin
                rx_cnt_q <= '0;
                bit_q    <= '0;
                s_q      <= '0;
                state_q  <= S_ENCODE;
              end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
              end
            end
          end
          S_ENCODE: begin
            obuf_q[opos]      <= c0;
            obuf_q[opos + 1'b1] <= c1;
            s_q <= win[K-2:0];
            if (bit_q == BIT_LAST) begin
              idx_q   <= '0;
              state_q <= S_SEND;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          S_SEND: begin
            if (go) begin
              txd_q   <= obyte;
              pend_q  <= 1'b0;
              state_q <= S_HOLD;
            end
          end
          S_HOLD: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (!tx_busy) begin
              if (idx_q == IDX_LAST) begin
                idx_q   <= '0;
                fd_q    <= 1'b1;
                state_q <= S_COLLECT;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= S_SEND;
              end
            end
          end
          default: begin
            state_q <= S_COLLECT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// tb_conv_frame_encoder: three encoder configurations driven by directed
// steps; coded bytes are scoreboarded against a tap-sum reference model.
module tb_conv_frame_encoder;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  logic       a_rst, a_rxv, a_abort, a_req, a_txs, a_bsy, a_fd, a_ovr;
  logic       b_rst, b_rxv, b_abort, b_req, b_txs, b_bsy, b_fd, b_ovr;
  logic       c_rst, c_rxv, c_abort, c_req, c_txs, c_bsy, c_fd, c_ovr;
  logic [7:0] a_rxd, a_txd, b_rxd, b_txd, c_rxd, c_txd;
  logic       a_tb, b_tb, c_tb;
  int         a_bc, b_bc, c_bc;

  bq_t        qa, qb, qc;
  logic       prevs[3];
  int         ntx[3];
  int         nfd[3];
  logic [7:0] lastd[3];

  conv_frame_encoder #(.PAYLOAD_BYTES(1), .K(3), .G0(7), .G1(5),
    .TAIL(0), .AUTO_SEND(1)) u_a (
    .clk(clk), .rst(a_rst), .rx_valid(a_rxv), .rx_data(a_rxd),
    .abort(a_abort), .send_req(a_req), .tx_busy(a_tb),
    .tx_start(a_txs), .tx_data(a_txd), .busy(a_bsy),
    .frame_done(a_fd), .overrun(a_ovr));

  conv_frame_encoder #(.PAYLOAD_BYTES(4), .K(3), .G0(7), .G1(5),
    .TAIL(1), .AUTO_SEND(1)) u_b (
    .clk(clk), .rst(b_rst), .rx_valid(b_rxv), .rx_data(b_rxd),
    .abort(b_abort), .send_req(b_req), .tx_busy(b_tb),
    .tx_start(b_txs), .tx_data(b_txd), .busy(b_bsy),
    .frame_done(b_fd), .overrun(b_ovr));

  conv_frame_encoder #(.PAYLOAD_BYTES(2), .K(5), .G0(19), .G1(29),
    .TAIL(1), .AUTO_SEND(0)) u_c (
    .clk(clk), .rst(c_rst), .rx_valid(c_rxv), .rx_data(c_rxd),
    .abort(c_abort), .send_req(c_req), .tx_busy(c_tb),
    .tx_start(c_txs), .tx_data(c_txd), .busy(c_bsy),
    .frame_done(c_fd), .overrun(c_ovr));

  // Transmitter models: busy for 10 cycles starting the cycle after start.
  always @(posedge clk or posedge a_rst)
    if (a_rst) a_bc <= 0;
    else if (a_txs) a_bc <= 10;
    else if (a_bc > 0) a_bc <= a_bc - 1;
  always @(posedge clk or posedge b_rst)
    if (b_rst) b_bc <= 0;
    else if (b_txs) b_bc <= 10;
    else if (b_bc > 0) b_bc <= b_bc - 1;
  always @(posedge clk or posedge c_rst)
    if (c_rst) c_bc <= 0;
    else if (c_txs) c_bc <= 10;
    else if (c_bc > 0) c_bc <= c_bc - 1;
  assign a_tb = (a_bc != 0);
  assign b_tb = (b_bc != 0);
  assign c_tb = (c_bc != 0);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int id);
    case (id)
      0: return qa.pop_front();
      1: return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int id, input logic [7:0] d);
    case (id)
      0: qa.push_back(d);
      1: qb.push_back(d);
      default: qc.push_back(d);
    endcase
  endfunction

  // Reference: each coded bit is the XOR of generator taps over past inputs.
  function automatic bq_t ref_enc(input bq_t pl, input int k,
      input int g0, input int g1, input int tail);
    bq_t r;
    int pb, ib, nb, p;
    logic bt, c0, c1;
    logic [7:0] t;
    pb = pl.size();
    ib = 8 * pb + ((tail != 0) ? k - 1 : 0);
    nb = (2 * ib + 7) / 8;
    for (int i = 0; i < nb; i++) r.push_back(8'h00);
    for (int j = 0; j < ib; j++) begin
      c0 = 1'b0;
      c1 = 1'b0;
      for (int i = 0; i < k; i++) begin
        p  = j - i;
        bt = 1'b0;
        if (p >= 0 && p < 8 * pb) begin
          t  = pl[p / 8];
          bt = t[p % 8];
        end
        c0 = c0 ^ (g0[i] & bt);
        c1 = c1 ^ (g1[i] & bt);
      end
      t = r[(2 * j) / 8];
      t[(2 * j) % 8] = c0;
      r[(2 * j) / 8] = t;
      t = r[(2 * j + 1) / 8];
      t[(2 * j + 1) % 8] = c1;
      r[(2 * j + 1) / 8] = t;
    end
    return r;
  endfunction

  task automatic mon(input int id, input logic st, input logic bz,
      input logic fd, input logic [7:0] d);
    int sz;
    logic [7:0] e;
    if (st) begin
      chk($sformatf("u%0d start_legal", id), {bz, prevs[id]}, 0);
      sz = qsize(id);
      chk($sformatf("u%0d start_expected", id), sz != 0, 1);
      if (sz != 0) begin
        e = qpop(id);
        chk($sformatf("u%0d byte%0d", id, ntx[id]), d, e);
      end
      ntx[id]++;
      lastd[id] = d;
    end
    prevs[id] = st;
    if (fd) nfd[id]++;
  endtask

  always @(negedge clk) begin
    mon(0, a_txs, a_tb, a_fd, a_txd);
    mon(1, b_txs, b_tb, b_fd, b_txd);
    mon(2, c_txs, c_tb, c_fd, c_txd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input int id, input logic [7:0] d);
    case (id)
      0: begin a_rxv = 1'b1; a_rxd = d; end
      1: begin b_rxv = 1'b1; b_rxd = d; end
      default: begin c_rxv = 1'b1; c_rxd = d; end
    endcase
    tick();
    a_rxv = 1'b0;
    b_rxv = 1'b0;
    c_rxv = 1'b0;
  endtask

  task automatic frame(input int id, input bq_t pl);
    bq_t e;
    case (id)
      1: e = ref_enc(pl, 3, 7, 5, 1);
      2: e = ref_enc(pl, 5, 19, 29, 1);
      default: e = ref_enc(pl, 3, 7, 5, 0);
    endcase
    foreach (e[i]) qpush(id, e[i]);
    foreach (pl[i]) rx(id, pl[i]);
  endtask

  task automatic wait_tx(input int id, input int n, input int budget);
    int i = 0;
    while (ntx[id] < n && i < budget) begin
      tick();
      i++;
    end
    chk($sformatf("u%0d tx_count_reached", id), ntx[id] >= n, 1);
  endtask

  task automatic wait_fd(input int id, input int n, input int budget);
    int i = 0;
    while (nfd[id] < n && i < budget) begin
      tick();
      i++;
    end
    chk($sformatf("u%0d frame_done_reached", id), nfd[id] >= n, 1);
  endtask

  task automatic rand_frame(output bq_t p, input int n);
    p = {};
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
  endtask

  initial begin
    bq_t p;
    int i;
    int base;
    for (int k = 0; k < 3; k++) begin
      prevs[k] = 1'b0;
      ntx[k]   = 0;
      nfd[k]   = 0;
      lastd[k] = 8'h00;
    end
    {a_rst, b_rst, c_rst} = 3'b111;
    {a_rxv, b_rxv, c_rxv} = 3'b000;
    {a_abort, b_abort, c_abort} = 3'b000;
    {a_req, b_req, c_req} = 3'b000;
    a_rxd = 8'h00;
    b_rxd = 8'h00;
    c_rxd = 8'h00;
    repeat (3) tick();
    {a_rst, b_rst, c_rst} = 3'b000;
    tick();

    chk("rst tx_start", a_txs, 0);
    chk("rst tx_data", a_txd, 8'h00);
    chk("rst busy", a_bsy, 0);
    chk("rst frame_done", a_fd, 0);
    chk("rst overrun", a_ovr, 0);
    chk("rst busy_b", b_bsy, 0);

    // Single-byte frame 0x01 with exact start latency.
    qa.push_back(8'h37);
    qa.push_back(8'h00);
    rx(0, 8'h01);
    repeat (7) tick();
    chk("lat encode_last_no_start", a_txs, 0);
    chk("lat encode_busy", a_bsy, 1);
    tick();
    chk("lat first_send_start", a_txs, 1);
    chk("lat first_send_data", a_txd, 8'h37);
    wait_tx(0, 2, 100);
    wait_fd(0, 1, 100);
    repeat (20) tick();
    chk("a frame_done_once", nfd[0], 1);
    chk("a idle_after", a_bsy, 0);

    // 0xFF, then 0x01 accepted in the frame_done cycle.
    qa.push_back(8'h5B);
    qa.push_back(8'h55);
    rx(0, 8'hFF);
    i = 0;
    while (!a_fd && i < 200) begin
      tick();
      i++;
    end
    chk("a fd_seen", a_fd, 1);
    qa.push_back(8'h37);
    qa.push_back(8'h00);
    rx(0, 8'h01);
    wait_tx(0, 6, 200);
    wait_fd(0, 3, 100);

    // Four-byte tailed frame with overrun strobes during encoding.
    p = '{8'hA5, 8'h3C, 8'h01, 8'h80};
    frame(1, p);
    repeat (3) tick();
    rx(1, 8'hEE);
    rx(1, 8'h11);
    chk("b overrun_set", b_ovr, 1);
    wait_tx(1, 9, 400);
    wait_fd(1, 1, 100);
    chk("b byte_count", ntx[1], 9);
    chk("b last_high_nibble", lastd[1] & 8'hF0, 0);
    chk("b overrun_sticky", b_ovr, 1);

    // Abort mid-encode clears overrun and busy, nothing is sent.
    rand_frame(p, 4);
    foreach (p[k]) rx(1, p[k]);
    repeat (5) tick();
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    chk("b abort_busy", b_bsy, 0);
    chk("b abort_overrun", b_ovr, 0);
    repeat (60) tick();
    chk("b abort_no_tx", ntx[1], 9);

    // Random payloads against the model.
    for (int f = 0; f < 2; f++) begin
      rand_frame(p, 4);
      frame(1, p);
      wait_tx(1, 18 + 9 * f, 400);
      wait_fd(1, 2 + f, 100);
    end

    // Reset during WAIT of byte 2.
    base = ntx[1];
    rand_frame(p, 4);
    frame(1, p);
    wait_tx(1, base + 3, 400);
    repeat (4) tick();
    #2;
    b_rst = 1'b1;
    #1;
    chk("mrst tx_start", b_txs, 0);
    chk("mrst tx_data", b_txd, 8'h00);
    chk("mrst busy", b_bsy, 0);
    chk("mrst frame_done", b_fd, 0);
    chk("mrst overrun", b_ovr, 0);
    qb.delete();
    tick();
    b_rst = 1'b0;
    base = ntx[1];
    i = nfd[1];
    repeat (40) tick();
    chk("mrst no_tx_after", ntx[1], base);
    chk("mrst no_fd_after", nfd[1], i);
    rand_frame(p, 4);
    frame(1, p);
    wait_tx(1, base + 9, 400);
    wait_fd(1, i + 1, 100);

    // Request-paced sending.
    rand_frame(p, 2);
    frame(2, p);
    repeat (40) tick();
    chk("c no_start_without_req", ntx[2], 0);
    c_req = 1'b1;
    tick();
    c_req = 1'b0;
    wait_tx(2, 1, 20);
    for (int k = 0; k < 3; k++) begin
      c_req = 1'b1;
      tick();
      c_req = 1'b0;
      tick();
    end
    repeat (40) tick();
    chk("c one_release_for_three", ntx[2], 2);
    for (int k = 0; k < 3; k++) begin
      c_req = 1'b1;
      tick();
      c_req = 1'b0;
      repeat (20) tick();
    end
    wait_fd(2, 1, 100);
    chk("c byte_count", ntx[2], 5);
    chk("c frame_done_once", nfd[2], 1);

    chk("qa drained", qa.size(), 0);
    chk("qb drained", qb.size(), 0);
    chk("qc drained", qc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
